// File: rtl/sc_bi_window_counter.sv
// rtl/sc_bi_window_counter.sv - bipolar window counter for the scaled stochastic MAC output
//
// Purpose:
//   Counts the ones in a window of N = 2^WIN_LOG2 qualified samples of a
//   stochastic bitstream. The bipolar result 2*ones - N is presented through
//   a valid/ready handshake.
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst_n    asynchronous reset, active low
//   iBit     stochastic bitstream sample
//   iEn      sample qualifier; iBit is counted only when iEn=1
//   start    request to open a new window (honoured in IDLE, or in HOLD on acceptance)
//   oBusy    high while a window is being accumulated
//   oValid   result available
//   iReady   downstream accepts the result
//   oResult  signed two's-complement result 2*ones - N, range -N..+N

module sc_bi_window_counter #(
  parameter int WIN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iBit,
  input  logic                iEn,
  input  logic                start,
  output logic                oBusy,
  output logic                oValid,
  input  logic                iReady,
  output logic [WIN_LOG2+1:0] oResult
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // Sample index of the final sample in a window (N-1).
  localparam logic [WIN_LOG2:0]   LAST_IDX = {1'b0, {WIN_LOG2{1'b1}}};
  // N expressed at result width, subtracted from 2*ones.
  localparam logic [WIN_LOG2+1:0] N_RES    = {2'b01, {WIN_LOG2{1'b0}}};

  logic [1:0]          state;
  logic [WIN_LOG2:0]   sample_cnt;
  logic [WIN_LOG2:0]   ones_cnt;
  logic [WIN_LOG2:0]   ones_next;
  logic [WIN_LOG2+1:0] result_next;
  logic                last_sample;
  logic                accept;

  // The final sample's bit must be included in the registered result, so the
  // result is formed from the incremented ones count rather than the register.
  assign ones_next   = ones_cnt + {{WIN_LOG2{1'b0}}, iBit};
  assign result_next = {ones_next, 1'b0} - N_RES;
  assign last_sample = iEn && (sample_cnt == LAST_IDX);

  // Outputs decode the state register only, so oValid never depends on iReady.
  assign oBusy  = (state == S_ACCUM);
  assign oValid = (state == S_HOLD);
  assign accept = oValid && iReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      ones_cnt   <= '0;
      oResult    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_ACCUM;
            sample_cnt <= '0;
            ones_cnt   <= '0;
          end
        end
        S_ACCUM: begin
          // start is deliberately ignored here; iEn=0 stalls both counters.
          if (iEn) begin
            sample_cnt <= sample_cnt + 1'b1;
            ones_cnt   <= ones_next;
            if (last_sample) begin
              state   <= S_HOLD;
              oResult <= result_next;
            end
          end
        end
        S_HOLD: begin
          // Samples arriving here are dropped; oResult is frozen until accepted
          // and keeps its value afterwards until the next window closes.
          if (accept) begin
            if (start) begin
              state      <= S_ACCUM;
              sample_cnt <= '0;
              ones_cnt   <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_bi_window_counter.sv
// tb/tb_sc_bi_window_counter.sv - directed bench for sc_bi_window_counter
//
// Purpose:
//   Linear directed stimulus with hand-computed expected values, checked by
//   immediate assertions. Window length N = 256, result width 10 bits.

module tb_sc_bi_window_counter;

  logic       clk;
  logic       rst_n;
  logic       iBit;
  logic       iEn;
  logic       start;
  logic       oBusy;
  logic       oValid;
  logic       iReady;
  logic [9:0] oResult;

  int checks;
  int failures;

  sc_bi_window_counter #(.WIN_LOG2(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iBit   (iBit),
    .iEn    (iEn),
    .start  (start),
    .oBusy  (oBusy),
    .oValid (oValid),
    .iReady (iReady),
    .oResult(oResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // Advance one rising edge, then settle 1 time unit before driving/sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ok;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    iBit     = 1'b0;
    iEn      = 1'b0;
    start    = 1'b0;
    iReady   = 1'b0;

    // Reset state
    step();
    check("reset_busy",   {31'b0, oBusy},  32'd0);
    check("reset_valid",  {31'b0, oValid}, 32'd0);
    check("reset_result", {22'b0, oResult}, 32'd0);
    rst_n = 1'b1;
    step();

    // Window 1: all ones -> +256, hold 20 cycles, accept
    start = 1'b1; iEn = 1'b1; iBit = 1'b1;
    step();                         // start edge
    start = 1'b0;
    check("w1_busy_after_start", {31'b0, oBusy}, 32'd1);
    for (int i = 0; i < 255; i++) step();
    check("w1_valid_before_last", {31'b0, oValid}, 32'd0);
    step();                         // 256th sample edge
    check("w1_valid",  {31'b0, oValid}, 32'd1);
    check("w1_busy",   {31'b0, oBusy},  32'd0);
    check("w1_result", {22'b0, oResult}, 32'h100);
    iBit = 1'b0;                    // samples in HOLD must be dropped
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!(oValid === 1'b1 && oResult === 10'h100)) ok = 1'b0;
    end
    check("w1_hold_stable", {31'b0, ok}, 32'd1);
    iReady = 1'b1;
    step();
    check("w1_valid_cleared", {31'b0, oValid}, 32'd0);
    check("w1_busy_idle",     {31'b0, oBusy},  32'd0);
    check("w1_result_holds",  {22'b0, oResult}, 32'h100);
    iReady = 1'b0;

    // Window 2: all zeros -> -256
    start = 1'b1; iBit = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 256; i++) step();
    check("w2_valid",  {31'b0, oValid}, 32'd1);
    check("w2_result", {22'b0, oResult}, 32'h300);
    iReady = 1'b1; step(); iReady = 1'b0;

    // Window 3: alternating 1/0 -> 0
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      iBit = (i % 2 == 0);
      step();
    end
    check("w3_valid",  {31'b0, oValid}, 32'd1);
    check("w3_result", {22'b0, oResult}, 32'h000);
    iReady = 1'b1; step(); iReady = 1'b0;

    // Window 4: exactly 192 ones -> +128
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      iBit = (i < 192);
      step();
    end
    check("w4_valid",  {31'b0, oValid}, 32'd1);
    check("w4_result", {22'b0, oResult}, 32'h080);
    iReady = 1'b1; step(); iReady = 1'b0;

    // Window 5: iEn every other cycle, iBit=1 only when iEn=0 -> 512 edges, -256
    start = 1'b1;
    step();
    start = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 512; c++) begin
      iEn  = (c % 2 == 1);
      iBit = !iEn;
      if (oBusy !== 1'b1 || oValid !== 1'b0) ok = 1'b0;
      step();
    end
    check("w5_busy_throughout", {31'b0, ok}, 32'd1);
    check("w5_valid",  {31'b0, oValid}, 32'd1);
    check("w5_result", {22'b0, oResult}, 32'h300);
    iEn = 1'b1;
    iReady = 1'b1; step(); iReady = 1'b0;

    // Back-to-back: start held high, all ones then all zeros
    start = 1'b1; iReady = 1'b1; iBit = 1'b1;
    step();
    for (int i = 0; i < 256; i++) step();
    check("b2b_first_valid",  {31'b0, oValid}, 32'd1);
    check("b2b_first_result", {22'b0, oResult}, 32'h100);
    iBit = 1'b0;
    step();                         // handshake + restart edge
    start = 1'b0;
    check("b2b_restart_busy",  {31'b0, oBusy},  32'd1);
    check("b2b_restart_valid", {31'b0, oValid}, 32'd0);
    iReady = 1'b0;
    for (int i = 0; i < 255; i++) step();
    check("b2b_second_not_early", {31'b0, oValid}, 32'd0);
    step();
    check("b2b_second_valid",  {31'b0, oValid}, 32'd1);
    check("b2b_second_result", {22'b0, oResult}, 32'h300);
    iReady = 1'b1; step(); iReady = 1'b0;

    // Async reset at sample 100 of an all-ones window
    start = 1'b1; iBit = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100; i++) step();
    rst_n = 1'b0;
    #1;
    check("rst_busy",   {31'b0, oBusy},  32'd0);
    check("rst_valid",  {31'b0, oValid}, 32'd0);
    check("rst_result", {22'b0, oResult}, 32'd0);
    step();
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (oValid !== 1'b0 || oBusy !== 1'b0) ok = 1'b0;
    end
    check("rst_quiet_300", {31'b0, ok}, 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 256; i++) step();
    check("rst_fresh_valid",  {31'b0, oValid}, 32'd1);
    check("rst_fresh_result", {22'b0, oResult}, 32'h100);
    iReady = 1'b1; step(); iReady = 1'b0;

    // start pulsed at sample 50 is ignored; result still at sample 256
    start = 1'b1; iBit = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      start = (i == 50);
      if (i == 255) check("mid_start_not_early", {31'b0, oValid}, 32'd0);
      step();
    end
    start = 1'b0;
    check("mid_start_valid",  {31'b0, oValid}, 32'd1);
    check("mid_start_result", {22'b0, oResult}, 32'h100);
    iReady = 1'b1; step(); iReady = 1'b0;
    check("mid_start_idle", {31'b0, oValid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
